// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: lock state encoding and port indices.
package dmem_arbiter_pkg;

  localparam int unsigned NUM_PORTS = 2;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_P0   = 2'd1,
    LOCK_P1   = 2'd2
  } lock_state_t;

  // Lock state that gives exclusive ownership to the given port.
  function automatic lock_state_t lock_of(input logic port);
    return port ? LOCK_P1 : LOCK_P0;
  endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// Combinational one-hot grant: lock owner only when locked, else the valid port
// or the preferred port on conflict.
module dmem_arb_grant
  import dmem_arbiter_pkg::*;
(
  input  logic                 enable,
  input  logic [NUM_PORTS-1:0] valid,
  input  lock_state_t          lock_state,
  input  logic                 prio,
  output logic [NUM_PORTS-1:0] grant
);

  always_comb begin
    grant = '0;
    if (enable) begin
      case (lock_state)
        LOCK_P0: grant[PORT_CORE] = valid[PORT_CORE];
        LOCK_P1: grant[PORT_DBG]  = valid[PORT_DBG];
        default: begin
          if (&valid) grant[prio] = 1'b1;
          else        grant = valid;
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (core = port 0, debug/loader = port 1) with lock
// ownership and one-cycle response routing. Define DMEM_ARB_RR_EN for round-robin.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic              req0_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic              req1_lock,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lock_state_t          lock_state;
  logic [NUM_PORTS-1:0] grant;
  logic                 prio;
  logic                 gnt_port;
  logic                 sel_lock;
  logic                 rsp_pend;
  logic                 rsp_port;
  logic                 rsp_we;

`ifdef DMEM_ARB_RR_EN
  logic last_port;

  // Last-granted pointer; resets to port 1 so port 0 wins the first conflict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_port <= PORT_DBG;
    end else if (mem_en && lock_state == LOCK_NONE) begin
      last_port <= gnt_port;
    end
  end

  assign prio = ~last_port;
`else
  assign prio = PORT_CORE;
`endif

  // Grants are suppressed while reset is asserted.
  dmem_arb_grant u_grant (
    .enable     (rst),
    .valid      ({req1_valid, req0_valid}),
    .lock_state (lock_state),
    .prio       (prio),
    .grant      (grant)
  );

  assign req0_ready = grant[PORT_CORE];
  assign req1_ready = grant[PORT_DBG];
  assign gnt_port   = grant[PORT_DBG];

  // Memory request mux; all fields zero when nothing is granted.
  always_comb begin
    mem_en    = |grant;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    sel_lock  = 1'b0;
    if (grant[PORT_CORE]) begin
      mem_we    = req0_we;
      mem_addr  = req0_addr;
      mem_wdata = req0_wdata;
      sel_lock  = req0_lock;
    end else if (grant[PORT_DBG]) begin
      mem_we    = req1_we;
      mem_addr  = req1_addr;
      mem_wdata = req1_wdata;
      sel_lock  = req1_lock;
    end
  end

  // Lock FSM: only the owner can be granted while locked, so any grant in a
  // locked state is an owner access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_state <= LOCK_NONE;
    end else if (mem_en) begin
      case (lock_state)
        LOCK_NONE: if (sel_lock)  lock_state <= lock_of(gnt_port);
        default:   if (!sel_lock) lock_state <= LOCK_NONE;
      endcase
    end
  end

  // Response tag for the access issued this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_pend <= 1'b0;
      rsp_port <= PORT_CORE;
      rsp_we   <= 1'b0;
    end else begin
      rsp_pend <= mem_en;
      rsp_port <= gnt_port;
      rsp_we   <= mem_we;
    end
  end

  assign rsp0_valid = rsp_pend && (rsp_port == PORT_CORE);
  assign rsp1_valid = rsp_pend && (rsp_port == PORT_DBG);
  assign rsp0_rdata = (rsp0_valid && !rsp_we) ? mem_rdata : '0;
  assign rsp1_rdata = (rsp1_valid && !rsp_we) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small synchronous-read memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we, req0_lock;
  logic [31:0] req0_addr, req0_wdata;
  logic        rsp0_valid;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we, req1_lock;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp1_valid;
  logic [31:0] rsp1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [16];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_lock  (req0_lock),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_lock  (req1_lock),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[5:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic we, input logic lk,
                      input logic [31:0] a, input logic [31:0] d);
    req0_valid = v; req0_we = we; req0_lock = lk; req0_addr = a; req0_wdata = d;
  endtask

  task automatic drv1(input logic v, input logic we, input logic lk,
                      input logic [31:0] a, input logic [31:0] d);
    req1_valid = v; req1_we = we; req1_lock = lk; req1_addr = a; req1_wdata = d;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    logic exp0;
    rst = 1'b0;
    drv0(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    #1;
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_rsp0_rdata", rsp0_rdata, 32'd0);
    step();
    rst = 1'b1;

    // Seed words 0x0 and 0x4, then write 0x10 and read it back
    drv0(1'b1, 1'b1, 1'b0, 32'h0, 32'h1111_1111);
    step();
    drv0(1'b1, 1'b1, 1'b0, 32'h4, 32'h2222_2222);
    step();
    drv0(1'b1, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
    #1;
    check("wr_ready0", 32'(req0_ready), 32'd1);
    check("wr_mem_we", 32'(mem_we), 32'd1);
    check("wr_mem_addr", mem_addr, 32'h10);
    check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    step();
    check("wr_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("wr_rsp0_rdata", rsp0_rdata, 32'd0);
    drv0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    #1;
    check("rd_mem_we", 32'(mem_we), 32'd0);
    check("rd_mem_en", 32'(mem_en), 32'd1);
    check("rd_mem_wdata", mem_wdata, 32'd0);
    step();
    check("rd_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("rd_rsp0_rdata", rsp0_rdata, 32'hDEAD_BEEF);
    check("rd_rsp1_valid", 32'(rsp1_valid), 32'd0);
    drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("idle_mem_en", 32'(mem_en), 32'd0);
    check("idle_mem_addr", mem_addr, 32'd0);
    step();
    check("idle_rsp0_valid", 32'(rsp0_valid), 32'd0);

    // Both ports read every cycle after a fresh reset
    do_reset();
    drv0(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drv1(1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp0 = (i % 2 == 0);
`else
      exp0 = 1'b1;
`endif
      #1;
      check($sformatf("conf%0d_ready0", i), 32'(req0_ready), 32'(exp0));
      check($sformatf("conf%0d_ready1", i), 32'(req1_ready), 32'(!exp0));
      step();
      check($sformatf("conf%0d_rsp0_valid", i), 32'(rsp0_valid), 32'(exp0));
      check($sformatf("conf%0d_rsp1_valid", i), 32'(rsp1_valid), 32'(!exp0));
      check($sformatf("conf%0d_rdata", i), exp0 ? rsp0_rdata : rsp1_rdata,
            exp0 ? 32'h1111_1111 : 32'h2222_2222);
    end
    drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Port 1 lock=1,1,0 with port 0 waiting
    drv1(1'b1, 1'b1, 1'b1, 32'h8, 32'h0000_A5A5);
    #1;
    check("lk_a_ready1", 32'(req1_ready), 32'd1);
    check("lk_a_mem_addr", mem_addr, 32'h8);
    step();
    check("lk_a_rsp1_valid", 32'(rsp1_valid), 32'd1);
    check("lk_a_rsp1_rdata", rsp1_rdata, 32'd0);
    drv0(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drv1(1'b1, 1'b0, 1'b1, 32'h8, 32'h0);
    #1;
    check("lk_b_ready0", 32'(req0_ready), 32'd0);
    check("lk_b_ready1", 32'(req1_ready), 32'd1);
    step();
    check("lk_b_rsp1_rdata", rsp1_rdata, 32'h0000_A5A5);
    check("lk_b_rsp0_valid", 32'(rsp0_valid), 32'd0);
    drv1(1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
    #1;
    check("lk_c_ready0", 32'(req0_ready), 32'd0);
    check("lk_c_ready1", 32'(req1_ready), 32'd1);
    step();
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("lk_d_ready0", 32'(req0_ready), 32'd1);
    step();
    check("lk_d_rsp0_rdata", rsp0_rdata, 32'h1111_1111);
    drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Owner drops valid while holding the lock
    drv1(1'b1, 1'b0, 1'b1, 32'h4, 32'h0);
    step();
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drv0(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("hold%0d_ready0", i), 32'(req0_ready), 32'd0);
      check($sformatf("hold%0d_mem_en", i), 32'(mem_en), 32'd0);
      step();
    end
    drv1(1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    #1;
    check("unlk_ready1", 32'(req1_ready), 32'd1);
    check("unlk_ready0", 32'(req0_ready), 32'd0);
    step();
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("unlk_after_ready0", 32'(req0_ready), 32'd1);
    step();
    drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Reset while port 0 holds the lock with a read in flight
    drv0(1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
    step();
    drv0(1'b1, 1'b0, 1'b1, 32'h4, 32'h0);
    #1;
    check("rl_ready0", 32'(req0_ready), 32'd1);
    rst = 1'b0;
    #1;
    check("rl_ready0_in_rst", 32'(req0_ready), 32'd0);
    step();
    check("rl_rsp0_valid_a", 32'(rsp0_valid), 32'd0);
    drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check("rl_rsp0_valid_b", 32'(rsp0_valid), 32'd0);
    rst = 1'b1;
    drv1(1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    #1;
    check("rl_ready1", 32'(req1_ready), 32'd1);
    check("rl_rsp0_valid_c", 32'(rsp0_valid), 32'd0);
    step();
    check("rl_rsp1_valid", 32'(rsp1_valid), 32'd1);
    check("rl_rsp1_rdata", rsp1_rdata, 32'h2222_2222);
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Back-to-back single-port reads on alternating ports
    drv0(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drv1(1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    #1;
    check("b2b_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("b2b_rsp0_rdata", rsp0_rdata, 32'h1111_1111);
    check("b2b_rsp1_valid_a", 32'(rsp1_valid), 32'd0);
    step();
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("b2b_rsp1_valid", 32'(rsp1_valid), 32'd1);
    check("b2b_rsp1_rdata", rsp1_rdata, 32'h2222_2222);
    check("b2b_rsp0_valid_b", 32'(rsp0_valid), 32'd0);
    check("b2b_rsp0_rdata_b", rsp0_rdata, 32'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
